// File: rtl/mux_l1_sched_pkg.sv
// Shared types and constants for the first-layer mux scheduler.
package mux_l1_sched_pkg;

  localparam int unsigned BURST_MAX = 15;
  localparam int unsigned NUM_IN    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GRP0 = 2'b01,
    GRP1 = 2'b10
  } schedState_t;

  // Inputs served by each group: group 0 -> {0,2}, group 1 -> {1,3}.
  function automatic logic [NUM_IN-1:0] grpMask(input schedState_t s);
    logic [NUM_IN-1:0] m;
    m = '0;
    case (s)
      GRP0:    m = 4'b0101;
      GRP1:    m = 4'b1010;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mux_l1_sched_if.sv
// Upstream valid/pop and downstream select/pause signals of one mux layer.
interface mux_l1_sched_if;
  logic validIn0;
  logic validIn1;
  logic validIn2;
  logic validIn3;
  logic pause;
  logic selector;
  logic pop0;
  logic pop1;
  logic pop2;
  logic pop3;
  logic busy;

  modport master (
    output validIn0, validIn1, validIn2, validIn3, pause,
    input  selector, pop0, pop1, pop2, pop3, busy
  );

  modport slave (
    input  validIn0, validIn1, validIn2, validIn3, pause,
    output selector, pop0, pop1, pop2, pop3, busy
  );
endinterface

// File: rtl/mux_l1_sched_burst_cnt.sv
// Per-grant burst counter; expire flags the last allowed pop cycle of a grant.
module mux_l1_sched_burst_cnt #(
  parameter int unsigned BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic expire
);
  localparam int unsigned CW = $clog2(BURST + 1);

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(BURST - 1));

  // Hold wins over clear so a paused grant keeps its position.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mux_l1_sched.sv
// Round-robin group scheduler owning the shared selector of the first mux layer.
module mux_l1_sched
  import mux_l1_sched_pkg::*;
#(
  parameter int unsigned BURST = 4
) (
  input  logic           clk,
  input  logic           reset,
  mux_l1_sched_if.slave  bus
);

  if (BURST < 1 || BURST > BURST_MAX) begin : gBadBurst
    $error("mux_l1_sched: BURST out of range");
  end

  schedState_t       state;
  schedState_t       stateNext;
  logic              lastGrp;
  logic              lastGrpNext;
  logic              selReg;
  logic              selNext;
  logic              busyReg;
  logic [NUM_IN-1:0] validVec;
  logic [NUM_IN-1:0] popVec;
  logic              req0;
  logic              req1;
  logic              curReq;
  logic              othReq;
  logic              popCycle;
  logic              cntInc;
  logic              cntClr;
  logic              cntHold;
  logic              expire;

  assign validVec = {bus.validIn3, bus.validIn2, bus.validIn1, bus.validIn0};
  assign req0     = bus.validIn0 | bus.validIn2;
  assign req1     = bus.validIn1 | bus.validIn3;

  mux_l1_sched_burst_cnt #(.BURST(BURST)) uBurstCnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (cntInc),
    .clr    (cntClr),
    .hold   (cntHold),
    .expire (expire)
  );

  // Next state, Mealy pops and counter control.
  always_comb begin
    stateNext   = state;
    lastGrpNext = lastGrp;
    cntInc      = 1'b0;
    cntClr      = 1'b0;
    cntHold     = bus.pause;
    popVec      = '0;
    curReq      = 1'b0;
    othReq      = 1'b0;

    if (!bus.pause && !reset) begin
      popVec = validVec & grpMask(state);
    end
    popCycle = |popVec;

    unique case (state)
      IDLE: begin
        if (!bus.pause) begin
          cntClr = 1'b1;
          if (lastGrp) begin
            if (req0)      stateNext = GRP0;
            else if (req1) stateNext = GRP1;
          end else begin
            if (req1)      stateNext = GRP1;
            else if (req0) stateNext = GRP0;
          end
        end
      end
      GRP0, GRP1: begin
        curReq = (state == GRP0) ? req0 : req1;
        othReq = (state == GRP0) ? req1 : req0;
        if (!bus.pause) begin
          if (popCycle) begin
            cntInc      = 1'b1;
            lastGrpNext = (state == GRP1);
          end
          if ((popCycle && expire) || !curReq) begin
            cntClr = 1'b1;
            if (othReq)      stateNext = (state == GRP0) ? GRP1 : GRP0;
            else if (curReq) stateNext = state;
            else             stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    // Selector follows the granted group and holds through IDLE.
    selNext = selReg;
    if (stateNext == GRP0) selNext = 1'b0;
    if (stateNext == GRP1) selNext = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lastGrp <= 1'b1;
      selReg  <= 1'b0;
      busyReg <= 1'b0;
    end else begin
      state   <= stateNext;
      lastGrp <= lastGrpNext;
      selReg  <= selNext;
      busyReg <= (stateNext != IDLE);
    end
  end

  assign bus.selector = selReg;
  assign bus.busy     = busyReg;
  assign bus.pop0     = popVec[0];
  assign bus.pop1     = popVec[1];
  assign bus.pop2     = popVec[2];
  assign bus.pop3     = popVec[3];

endmodule
